// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_ctrl_pkg : register map and field definitions for apb_uart_rx_ctrl     |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
package uart_ctrl_pkg;

  localparam logic [4:0] OFS_DIV    = 5'h00;
  localparam logic [4:0] OFS_CTRL   = 5'h04;
  localparam logic [4:0] OFS_STATUS = 5'h08;
  localparam logic [4:0] OFS_RXDATA = 5'h0C;
  localparam logic [4:0] OFS_IRQ_EN = 5'h10;
  localparam logic [4:0] OFS_LEVEL  = 5'h14;
  localparam logic [4:0] OFS_UNMAP0 = 5'h18;
  localparam logic [4:0] OFS_UNMAP1 = 5'h1C;

  localparam int CTRL_STOP    = 0;
  localparam int CTRL_PAR_LSB = 1;
  localparam int CTRL_PAR_MSB = 3;
  localparam int CTRL_RX_EN   = 4;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_PAR_ERR  = 2;
  localparam int ST_STOP_ERR = 3;
  localparam int ST_DROPPED  = 4;

  localparam int IRQ_NONEMPTY = 0;
  localparam int IRQ_PAR      = 1;
  localparam int IRQ_STOP     = 2;
  localparam int IRQ_DROPPED  = 3;

  typedef enum logic [2:0] {
    PAR_SPACE = 3'd0,
    PAR_MARK  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_EVEN  = 3'd3,
    PAR_NONE  = 3'd4
  } parity_mode_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_sync_fifo : single-clock FIFO with occupancy counter                   |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guard here as well so the FIFO never corrupts itself on a misbehaving caller.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_uart_rx_ctrl : APB3 config/status/RX-FIFO front end for the UART RX     |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module apb_uart_rx_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] DIV_RST    = 32'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [7:0]  saxis_tdata_i,
  input  logic        saxis_tvalid_i,
  output logic        saxis_tready_o,
  input  logic        err_rx_i,
  input  logic        err_stop_i,
  input  logic        err_rx_dropped_i,
  output logic [31:0] delitel,
  output logic        stop_bit_num,
  output logic [2:0]  parity_bit_mode,
  output logic        irq
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] IDX_DIV    = OFS_DIV[4:2];
  localparam logic [2:0] IDX_CTRL   = OFS_CTRL[4:2];
  localparam logic [2:0] IDX_STATUS = OFS_STATUS[4:2];
  localparam logic [2:0] IDX_RXDATA = OFS_RXDATA[4:2];
  localparam logic [2:0] IDX_IRQ_EN = OFS_IRQ_EN[4:2];
  localparam logic [2:0] IDX_LEVEL  = OFS_LEVEL[4:2];
  localparam logic [2:0] IDX_UNMAP0 = OFS_UNMAP0[4:2];
  localparam logic [2:0] IDX_UNMAP1 = OFS_UNMAP1[4:2];

  logic [31:0] div_q, div_d;
  logic        stop_bit_q, stop_bit_d;
  logic [2:0]  parity_q, parity_d;
  logic        rx_en_q, rx_en_d;
  logic [3:0]  irq_en_q, irq_en_d;
  logic        par_err_q, par_err_d;
  logic        stop_err_q, stop_err_d;
  logic        drop_err_q, drop_err_d;
  logic        err_rx_prev_q, err_stop_prev_q, err_drop_prev_q;
  logic        irq_q, irq_d;

  logic [2:0]    addr_idx;
  logic          wr_en;
  logic          rd_sel;
  logic          rd_access;
  logic          wr_status;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          w_unused_paddr;

  assign addr_idx       = paddr[4:2];
  assign w_unused_paddr = ^{paddr[31:5], paddr[1:0]};
  assign wr_en          = psel & penable & pwrite;
  assign rd_sel         = psel & ~pwrite;
  assign rd_access      = psel & penable & ~pwrite;
  assign wr_status      = wr_en & (addr_idx == IDX_STATUS);

  assign pready  = 1'b1;
  assign pslverr = psel & penable & ((addr_idx == IDX_UNMAP0) | (addr_idx == IDX_UNMAP1));

  // With RX disabled the receiver is drained and its bytes dropped, so it never stalls.
  assign saxis_tready_o = ~fifo_full | ~rx_en_q;
  assign fifo_push      = saxis_tvalid_i & saxis_tready_o & rx_en_q;
  assign fifo_pop       = rd_access & (addr_idx == IDX_RXDATA) & ~fifo_empty;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (saxis_tdata_i),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    div_d      = div_q;
    stop_bit_d = stop_bit_q;
    parity_d   = parity_q;
    rx_en_d    = rx_en_q;
    irq_en_d   = irq_en_q;
    if (wr_en) begin
      case (addr_idx)
        IDX_DIV:    div_d = (pwdata == 32'd0) ? 32'd1 : pwdata;
        IDX_CTRL: begin
          stop_bit_d = pwdata[CTRL_STOP];
          parity_d   = pwdata[CTRL_PAR_MSB:CTRL_PAR_LSB];
          rx_en_d    = pwdata[CTRL_RX_EN];
        end
        IDX_IRQ_EN: irq_en_d = pwdata[3:0];
        default: ;
      endcase
    end
  end

  // A fresh error edge wins over a W1C landing in the same cycle.
  always_comb begin
    par_err_d  = (err_rx_i & ~err_rx_prev_q) |
                 (par_err_q & ~(wr_status & pwdata[ST_PAR_ERR]));
    stop_err_d = (err_stop_i & ~err_stop_prev_q) |
                 (stop_err_q & ~(wr_status & pwdata[ST_STOP_ERR]));
    drop_err_d = (err_rx_dropped_i & ~err_drop_prev_q) |
                 (drop_err_q & ~(wr_status & pwdata[ST_DROPPED]));
  end

  always_comb begin
    irq_d = (drop_err_q  & irq_en_q[IRQ_DROPPED]) |
            (stop_err_q  & irq_en_q[IRQ_STOP])    |
            (par_err_q   & irq_en_q[IRQ_PAR])     |
            (~fifo_empty & irq_en_q[IRQ_NONEMPTY]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q           <= DIV_RST;
      stop_bit_q      <= 1'b0;
      parity_q        <= PAR_NONE;
      rx_en_q         <= 1'b1;
      irq_en_q        <= 4'h0;
      par_err_q       <= 1'b0;
      stop_err_q      <= 1'b0;
      drop_err_q      <= 1'b0;
      err_rx_prev_q   <= 1'b0;
      err_stop_prev_q <= 1'b0;
      err_drop_prev_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      div_q           <= div_d;
      stop_bit_q      <= stop_bit_d;
      parity_q        <= parity_d;
      rx_en_q         <= rx_en_d;
      irq_en_q        <= irq_en_d;
      par_err_q       <= par_err_d;
      stop_err_q      <= stop_err_d;
      drop_err_q      <= drop_err_d;
      err_rx_prev_q   <= err_rx_i;
      err_stop_prev_q <= err_stop_i;
      err_drop_prev_q <= err_rx_dropped_i;
      irq_q           <= irq_d;
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (rd_sel) begin
      case (addr_idx)
        IDX_DIV: prdata = div_q;
        IDX_CTRL: begin
          prdata[CTRL_STOP]                 = stop_bit_q;
          prdata[CTRL_PAR_MSB:CTRL_PAR_LSB] = parity_q;
          prdata[CTRL_RX_EN]                = rx_en_q;
        end
        IDX_STATUS: begin
          prdata[ST_EMPTY]    = fifo_empty;
          prdata[ST_FULL]     = fifo_full;
          prdata[ST_PAR_ERR]  = par_err_q;
          prdata[ST_STOP_ERR] = stop_err_q;
          prdata[ST_DROPPED]  = drop_err_q;
        end
        IDX_RXDATA: if (!fifo_empty) prdata[7:0] = fifo_dout;
        IDX_IRQ_EN: prdata[3:0] = irq_en_q;
        IDX_LEVEL:  prdata = 32'(fifo_level);
        default: ;
      endcase
    end
  end

  assign delitel         = div_q;
  assign stop_bit_num    = stop_bit_q;
  assign parity_bit_mode = parity_q;
  assign irq             = irq_q;

endmodule
`default_nettype wire

// File: doc/apb_uart_rx_ctrl.md
Name: apb_uart_rx_ctrl

Overview:
- APB3 slave that configures and services the AXIS UART receiver.
- Drives the receiver's divider, stop-bit and parity configuration.
- Buffers received bytes from the receiver's AXIS master output in a small FIFO, read by software through a data register.
- Converts the receiver's error outputs into sticky, write-1-to-clear status bits with a maskable interrupt.

Parameters:
- FIFO_DEPTH, 8, RX byte FIFO entries; power of two, ≥2.
- DIV_RST, 868, reset value of the divider register (100 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  32  APB address; only paddr[4:2] decoded
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready, tied 1
- pslverr  out  1  APB error
- saxis_tdata_i  in  8  byte from the receiver
- saxis_tvalid_i  in  1  byte valid from the receiver
- saxis_tready_o  out  1  ready to the receiver
- err_rx_i  in  1  receiver parity error (level, held until receiver reset)
- err_stop_i  in  1  receiver stop-bit error (level)
- err_rx_dropped_i  in  1  receiver dropped-frame flag (level)
- delitel  out  32  divider to the receiver
- stop_bit_num  out  1  0 = one stop bit, 1 = two stop bits
- parity_bit_mode  out  3  0 = space, 1 = mark, 2 = odd, 3 = even, other = none
- irq  out  1  interrupt, registered

Behaviour:
- Reset values:
  - delitel = DIV_RST; stop_bit_num = 0; parity_bit_mode = 3'h4 (none).
  - rx_en = 1; irq_en = 0; all sticky bits 0; FIFO empty.
  - irq = 0; pslverr = 0; prdata = 0.
- APB timing:
  - Zero wait states. A write commits on the clock edge where psel & penable & pwrite.
  - prdata is combinational from the register state during psel & ~pwrite.
- Register map (byte offsets):
  - 0x00 DIV: RW [31:0]. Value 0 is written as 1.
  - 0x04 CTRL: RW. [0] stop_bit_num, [3:1] parity_bit_mode, [4] rx_en.
  - 0x08 STATUS:
    - [0] fifo_empty, RO. [1] fifo_full, RO.
    - [2] parity_err, [3] stop_err, [4] dropped; each sticky, W1C.
  - 0x0C RXDATA: RO [7:0]. A read pops one entry. A read when empty returns 0, does not pop, and does not error.
  - 0x10 IRQ_EN: RW. [0] non-empty, [1] parity, [2] stop, [3] dropped.
  - 0x14 LEVEL: RO, [$clog2(FIFO_DEPTH):0] = FIFO occupancy.
  - 0x18, 0x1C: unmapped. pslverr = 1 in the access phase, reads return 0, writes are ignored.
  - Writes to RO registers are ignored, without error.
- Config outputs change one cycle after the write. The receiver samples them only while idle, so a mid-frame write takes effect from the next start bit. No extra gating is needed here.
- Sticky errors:
  - Set on the rising edge of each err input, detected with a registered copy of the input.
  - Set has priority over a W1C in the same cycle.
  - The edge-detect registers reset to 0, so an input that is already high after reset sets its bit once.
- FIFO and AXIS input:
  - saxis_tready_o = ~fifo_full | ~rx_en.
  - Push on tvalid & tready & rx_en. With rx_en = 0 bytes are accepted and discarded.
  - Full: tready stays low even if a pop occurs in the same cycle (registered full flag). The receiver then raises err_rx_dropped on its next frame.
  - Simultaneous push and pop: both occur and the level is unchanged. When empty, the pop is suppressed, the push lands, and the read returns 0.
  - Read and write pointers wrap modulo FIFO_DEPTH. The level counter is one bit wider than the pointer width.
- irq = |({dropped, stop_err, parity_err, ~fifo_empty} & irq_en[3:0]), registered, so it lags by one cycle.
- Asynchronous reset mid-operation clears the FIFO, sticky bits and config, regardless of APB or AXIS activity.

Decomposition:
- Package uart_ctrl_pkg holds:
  - Register offset localparams.
  - CTRL/STATUS/IRQ bit-index localparams.
  - A parity-mode enum (PAR_SPACE, PAR_MARK, PAR_ODD, PAR_EVEN, PAR_NONE) shared with the receiver benches.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level) is instantiated once.

Test Plan:
1. Reset, then read all registers -> DIV = 868, CTRL = 0x18, STATUS = 0x1, IRQ_EN = 0, LEVEL = 0, irq = 0.
2. Write DIV = 0x1B2 and CTRL = 0x07; read back -> delitel = 0x1B2, stop_bit_num = 1, parity_bit_mode = 3 next cycle. Write DIV = 0 -> reads 1.
3. Push bytes 0x11..0x18 via AXIS -> LEVEL = 8, fifo_full, tready = 0. Then 8 RXDATA reads -> 0x11..0x18 in order, and a 9th read returns 0 with LEVEL = 0.
4. Set IRQ_EN = 0x2 and pulse err_rx_i high then hold it -> STATUS[2] = 1, irq = 1. Write STATUS = 0x4 -> bit clears and irq drops, with no re-set while the input stays high.
5. Hold err_stop_i rising in the same cycle as a W1C of bit 3 -> bit 3 remains 1.
6. Access offset 0x18 -> pslverr = 1 and no state change. Assert rst_n low with FIFO LEVEL = 5 -> LEVEL = 0 and all outputs at reset values immediately.
